gpio_pad_bank: RTL

Parametrised multi-channel bidirectional pad controller. It is the next generation of the single tri-state pad wrapper. Per channel it provides a registered output-drive path, an input synchroniser, an optional glitch filter (debounce) and edge-detect interrupt generation. It sits between the SoC GPIO register block and the c2p/c2p_en/p2c pins of the I/O pad cells.

---
 rtl/gpio_pad_bank.sv | 103 ++++++++++
 1 files changed

// File: rtl/gpio_pad_bank.sv
// Multi-channel bidirectional pad controller: registered drive path, input
// synchroniser, per-channel debounce filter and edge-detect interrupt flags.
module gpio_pad_bank #(
  parameter int NUM_CH      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   cfg_dir,
  input  logic [NUM_CH-1:0]   cfg_out,
  input  logic [NUM_CH-1:0]   cfg_db_en,
  input  logic [DB_WIDTH-1:0] cfg_db_thr,
  input  logic [NUM_CH-1:0]   cfg_irq_rise,
  input  logic [NUM_CH-1:0]   cfg_irq_fall,
  input  logic [NUM_CH-1:0]   irq_clr,
  output logic [NUM_CH-1:0]   pad_c2p,
  output logic [NUM_CH-1:0]   pad_c2p_en,
  input  logic [NUM_CH-1:0]   pad_p2c,
  output logic [NUM_CH-1:0]   in_val,
  output logic [NUM_CH-1:0]   irq_pend,
  output logic                irq
);

  logic [NUM_CH-1:0] r_sync [SYNC_STAGES];
  logic [NUM_CH-1:0] w_s;
  logic [NUM_CH-1:0] w_in_val;
  logic [NUM_CH-1:0] w_set;
  logic [NUM_CH-1:0] r_in_prev;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_c2p;
  logic [NUM_CH-1:0] r_c2p_en;

  // Drive path: reset forces every pad to high-Z asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c2p    <= '0;
      r_c2p_en <= '0;
    end else begin
      r_c2p    <= cfg_out;
      r_c2p_en <= cfg_dir;
    end
  end

  // Synchroniser chain, sampled regardless of direction so outputs read back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= pad_p2c;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

  // Debounce filter: counter saturates, so a threshold lowered below the
  // current count stalls the channel until debounce is toggled off
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DB_WIDTH-1:0] r_cnt;
    logic                r_in;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_cnt <= '0;
        r_in  <= 1'b0;
      end else if (!cfg_db_en[g]) begin
        r_cnt <= '0;
        r_in  <= w_s[g];
      end else if (w_s[g] == r_in) begin
        r_cnt <= '0;
      end else if (r_cnt == cfg_db_thr) begin
        r_cnt <= '0;
        r_in  <= w_s[g];
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + DB_WIDTH'(1);
      end
    end

    assign w_in_val[g] = r_in;
  end

  assign w_set = (w_in_val & ~r_in_prev & cfg_irq_rise) |
                 (~w_in_val & r_in_prev & cfg_irq_fall);

  // Edge detect and pending flags; a coincident set overrides the clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_prev <= '0;
      r_pend    <= '0;
    end else begin
      r_in_prev <= w_in_val;
      r_pend    <= (r_pend & ~irq_clr) | w_set;
    end
  end

  assign pad_c2p    = r_c2p;
  assign pad_c2p_en = r_c2p_en;
  assign in_val     = w_in_val;
  assign irq_pend   = r_pend;
  assign irq        = |r_pend;

endmodule
